// File: rtl/channel_err_injector.sv
// Channel error injector: corrupts a stream of coded symbols with periodic or
// random bursts and independent random errors, and keeps saturating statistics.
module channel_err_injector #(
   parameter int          SYM_W       = 2,
   parameter int          PERIOD_LOG2 = 5,
   parameter int          BURST_LEN   = 4,
   parameter int          WINDOW      = 256,
   parameter int          CNT_W       = 16,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode_i,
   input  logic [7:0]       thresh_i,
   input  logic             valid_i,
   input  logic [SYM_W-1:0] sym_i,
   output logic             valid_o,
   output logic [SYM_W-1:0] sym_o,
   output logic [SYM_W-1:0] err_mask_o,
   output logic             burst_o,
   output logic [CNT_W-1:0] word_ct_o,
   output logic [CNT_W-1:0] err_sym_ct_o,
   output logic [CNT_W-1:0] err_bit_ct_o
);

   localparam int REM_W = $clog2(BURST_LEN + 1);

   localparam logic [1:0] MODE_PASS  = 2'd0;
   localparam logic [1:0] MODE_PER   = 2'd1;
   localparam logic [1:0] MODE_RAND  = 2'd2;
   localparam logic [1:0] MODE_RTRIG = 2'd3;

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [15:0]      lfsr_q, lfsr_nxt;
   logic [SYM_W-1:0] cand, mask;
   logic [CNT_W-1:0] pop;
   logic             rnd_hit, in_win, period_hit, trig, in_burst;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   // Galois form of x^16+x^14+x^13+x^11+1
   assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   // a zero candidate would make an "injected" symbol clean, so force one flip
   always_comb begin
      cand = lfsr_q[8 +: SYM_W];
      if (cand == '0) cand = SYM_W'(1);
   end

   assign rnd_hit    = lfsr_q[7:0] < thresh_i;
   assign in_win     = 32'(word_ct_o) < 32'(WINDOW);
   assign period_hit = &word_ct_o[PERIOD_LOG2-1:0];
   assign trig       = in_win && (((mode_i == MODE_PER) && period_hit) ||
                                  ((mode_i == MODE_RTRIG) && rnd_hit));

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      mask     = '0;
      in_burst = 1'b0;
      if (valid_i) begin
         if (mode_i == MODE_PASS) begin
            state_d = IDLE;
         end else if (state_q == BURST) begin
            // trigger is ignored here, so the earliest retrigger is the next symbol
            mask     = cand;
            in_burst = 1'b1;
            rem_d    = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) state_d = IDLE;
         end else if (trig) begin
            mask     = cand;
            in_burst = 1'b1;
            if (BURST_LEN > 1) begin
               state_d = BURST;
               rem_d   = REM_W'(BURST_LEN - 1);
            end
         end else if ((mode_i == MODE_RAND) && rnd_hit) begin
            mask = cand;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < SYM_W; i++) pop = pop + CNT_W'(mask[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else if (valid_i) begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o      <= 1'b0;
         sym_o        <= '0;
         err_mask_o   <= '0;
         burst_o      <= 1'b0;
         word_ct_o    <= '0;
         err_sym_ct_o <= '0;
         err_bit_ct_o <= '0;
         lfsr_q       <= SEED;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            lfsr_q       <= lfsr_nxt;
            sym_o        <= sym_i ^ mask;
            err_mask_o   <= mask;
            burst_o      <= in_burst;
            word_ct_o    <= sat_add(word_ct_o, CNT_W'(1));
            err_sym_ct_o <= sat_add(err_sym_ct_o, CNT_W'(|mask));
            err_bit_ct_o <= sat_add(err_bit_ct_o, pop);
         end
      end
   end

endmodule
